// File: rtl/mem_access_unit.sv
// mem_access_unit
// Multicycle load/store initiator between the CPU datapath and a word-addressed
// data memory. One byte/halfword/word request is accepted at a time from IDLE.
// The byte address becomes a word index plus byte enables. Store data is
// replicated across the lanes, and a single-cycle memory access is issued.
// Load data is lane-extracted, sign- or zero-extended and registered.
// Misaligned and reserved-size requests are rejected without touching memory.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   req    in   1   access request (sampled only in IDLE)
//   we     in   1   1 = store, 0 = load
//   size   in   2   00 byte, 01 half, 10 word, 11 reserved
//   sext   in   1   loads: 1 = sign-extend, 0 = zero-extend
//   baddr  in  32   byte address
//   wdata  in  32   right-justified store data
//   busy   out  1   high in ACCESS, DONE and ERR
//   done   out  1   one-cycle completion pulse
//   err    out  1   one-cycle rejection pulse
//   rdata  out 32   extended load result, held until the next completed load
//   DMWr   out  1   memory write enable (only in ACCESS)
//   addr   out 32   memory word index
//   be     out  4   memory byte enables (0000 outside ACCESS)
//   din    out 32   memory write data
//   dout   in  32   memory read data, combinational from addr
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] baddr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        DMWr,
  output logic [31:0] addr,
  output logic [3:0]  be,
  output logic [31:0] din,
  input  logic [31:0] dout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] din_q, din_d;
  logic [31:0] rdata_q, rdata_d;
  logic        dmwr_q, dmwr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Alignment rule: halfwords on even bytes, words on multiples of four.
  function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] off);
    logic ok;
    case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = (off[0] == 1'b0);
      2'b10:   ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte enables for an already-legal access.
  function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] off);
    logic [3:0] m;
    case (sz)
      2'b00:   m = 4'b0001 << off;
      2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate right-justified store data onto every lane; be selects the live ones.
  function automatic logic [31:0] lanes_of(input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] d;
    case (sz)
      2'b00:   d = {4{wd[7:0]}};
      2'b01:   d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  // Pick the addressed lane out of the memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic sx,
                                               input logic [1:0] off, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = sx ? {{24{b[7]}}, b} : {24'h000000, b};
      2'b01:   r = sx ? {{16{h[15]}}, h} : {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // State and output registers; reset also kills an in-flight write at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      din_q   <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
      dmwr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      dmwr_q  <= dmwr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic; flags are derived from the next state
  // so that every output leaves a flop.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = 4'b0000;
    din_d   = din_q;
    rdata_d = rdata_q;
    dmwr_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (is_legal(size, baddr[1:0])) begin
            we_d    = we;
            size_d  = size;
            sext_d  = sext;
            off_d   = baddr[1:0];
            addr_d  = {2'b00, baddr[31:2]};
            be_d    = be_of(size, baddr[1:0]);
            din_d   = lanes_of(size, wdata);
            dmwr_d  = we;
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // dout is valid during this cycle because addr is already registered.
        if (!we_q) begin
          rdata_d = load_extract(size_q, sext_q, off_q, dout);
        end else begin
          rdata_d = rdata_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) begin
      busy_d = 1'b0;
    end else begin
      busy_d = 1'b1;
    end
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;
  assign DMWr  = dmwr_q;
  assign addr  = addr_q;
  assign be    = be_q;
  assign din   = din_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit. The reference memory is a plain byte
// array; expected responses are computed from it when a request is accepted
// and are compared by an independent monitor when done/err/access appear.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sext;
  logic [1:0]  size;
  logic [31:0] baddr, wdata;
  logic        busy, done, err, DMWr;
  logic [31:0] rdata, addr, din, dout;
  logic [3:0]  be;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .baddr(baddr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .DMWr(DMWr), .addr(addr), .be(be), .din(din), .dout(dout)
  );

  // Word-organised memory attached to the DUT (64 words, indexed by addr[5:0]).
  logic [31:0] mem [0:63];
  logic        bw_en = 1'b0;
  logic [5:0]  bw_idx = 6'd0;
  logic [31:0] bw_data = 32'h0;
  assign dout = mem[addr[5:0]];

  always @(posedge clk) begin
    if (bw_en) begin
      mem[bw_idx] <= bw_data;
    end else if (DMWr) begin
      for (int j = 0; j < 4; j++)
        if (be[j]) mem[addr[5:0]][8*j +: 8] <= din[8*j +: 8];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: byte-addressed memory plus the last completed load value.
  logic [7:0]  ref_b [0:255];
  logic [31:0] last_rd = 32'h0;

  typedef struct {
    bit          is_err;
    bit          is_load;
    int unsigned acc_cyc;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_din;
    logic [31:0] exp_rdata;
    logic [5:0]  widx;
    logic [31:0] exp_word;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [5:0] widx);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[8*j +: 8] = ref_b[{widx, 2'b00} + 8'(j)];
    return w;
  endfunction

  // Compute the expected outcome of the request currently on the inputs and
  // apply it to the reference memory.
  task automatic push_req();
    exp_t        e;
    int          n;
    int          off;
    logic [7:0]  ba;
    logic [31:0] raw, mask;
    n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(baddr[1:0]);
    ba  = baddr[7:0];
    e.acc_cyc  = cyc;
    e.widx     = baddr[7:2];
    e.exp_addr = baddr >> 2;
    e.is_load  = !we;
    e.exp_be   = 4'b0000;
    e.exp_din  = 32'h0;
    e.is_err   = (size == 2'd3) || ((off % n) != 0);
    if (!e.is_err) begin
      for (int j = 0; j < 4; j++) begin
        e.exp_be[j] = (j >= off) && (j < off + n);
        e.exp_din[8*j +: 8] = wdata[8*(j % n) +: 8];
      end
      if (we) begin
        for (int i = 0; i < n; i++) ref_b[ba + 8'(i)] = wdata[8*i +: 8];
      end else begin
        raw = 32'h0;
        for (int i = 0; i < n; i++) raw[8*i +: 8] = ref_b[ba + 8'(i)];
        if (sext && n < 4 && raw[8*n-1]) begin
          mask = (32'h1 << (8*n)) - 32'h1;
          raw  = raw | ~mask;
        end
        last_rd = raw;
      end
    end
    e.exp_rdata = last_rd;
    e.exp_word  = word_of(e.widx);
    sb_q.push_back(e);
  endtask

  // One request: present it, it is accepted at the next edge, then leave the
  // unit alone for its full latency plus a random idle gap.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] ba, input logic [31:0] wd, input int gap);
    bit legal;
    we = w; size = sz; sext = sx; baddr = ba; wdata = wd; req = 1'b1;
    legal = (sz != 2'd3) && ((sz == 2'd0) || (sz == 2'd1 && !ba[0]) || (sz == 2'd2 && ba[1:0] == 2'b00));
    @(posedge clk); #1;
    req = 1'b0;
    push_req();
    repeat (legal ? 2 : 1) @(posedge clk);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_done"}, {31'h0, done}, 32'h0);
    check({tag, "_err"},  {31'h0, err},  32'h0);
    check({tag, "_dmwr"}, {31'h0, DMWr}, 32'h0);
    check({tag, "_addr"}, addr, 32'h0);
    check({tag, "_din"},  din,  32'h0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_be"},   {28'h0, be}, 32'h0);
  endtask

  task automatic busy_window();
    check("b2b_busy_access", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    check("b2b_busy_done", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    check("b2b_busy_idle", {31'h0, busy}, 32'h0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (be != 4'b0000) begin
        if (sb_q.size() == 0) begin
          check("unexpected_access", {28'h0, be}, 32'h0);
        end else begin
          e = sb_q[0];
          check("access_on_rejected", {31'h0, e.is_err}, 32'h0);
          check("access_cycle", cyc, e.acc_cyc);
          check("access_addr", addr, e.exp_addr);
          check("access_be", {28'h0, be}, {28'h0, e.exp_be});
          check("access_dmwr", {31'h0, DMWr}, {31'h0, !e.is_load});
          if (!e.is_load) check("access_din", din, e.exp_din);
        end
      end else begin
        check("dmwr_outside_access", {31'h0, DMWr}, 32'h0);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'h0, done}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("done_on_rejected", {31'h0, e.is_err}, 32'h0);
          check("done_cycle", cyc, e.acc_cyc + 1);
          check("done_rdata", rdata, e.exp_rdata);
          check("done_mem_word", mem[e.widx], e.exp_word);
          check("done_busy", {31'h0, busy}, 32'h1);
          check("done_err_clear", {31'h0, err}, 32'h0);
        end
      end
      if (err) begin
        if (sb_q.size() == 0) begin
          check("unexpected_err", {31'h0, err}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("err_on_legal", {31'h0, e.is_err}, 32'h1);
          check("err_cycle", cyc, e.acc_cyc);
          check("err_rdata_hold", rdata, e.exp_rdata);
          check("err_mem_word", mem[e.widx], e.exp_word);
          check("err_busy", {31'h0, busy}, 32'h1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0d required completion", busy);
    $fatal(1);
  end

  initial begin
    logic [31:0] w, r;
    logic [1:0]  sz;
    req = 1'b0; we = 1'b0; size = 2'd0; sext = 1'b0; baddr = 32'h0; wdata = 32'h0;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");

    // Fill the memory and the reference with the same random contents.
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      bw_en = 1'b1; bw_idx = 6'(i); bw_data = w;
      for (int j = 0; j < 4; j++) ref_b[4*i + j] = w[8*j +: 8];
      @(posedge clk); #1;
    end
    bw_en = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Word store then load.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
    issue(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, 1);
    // Byte lanes over 0x80FF7F01.
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 0);
    for (int k = 0; k < 4; k++) issue(1'b0, 2'd0, 1'b1, 32'h10 + 32'(k), 32'h0, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0);
    // Halfword store/load.
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234ABCD, 0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
    // Rejected requests.
    issue(1'b1, 2'd2, 1'b0, 32'h11, 32'h55555555, 0);
    issue(1'b1, 2'd1, 1'b0, 32'h13, 32'h66666666, 0);
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h77777777, 1);

    // Reset during ACCESS of a store.
    we = 1'b1; size = 2'd2; sext = 1'b0; baddr = 32'h20; wdata = 32'hA5A5A5A5; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("midop");
    last_rd = 32'h0;
    @(posedge clk); #1;
    check("midop_mem_word", mem[6'h08], word_of(6'h08));
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // req held high across three legal loads.
    req = 1'b1; we = 1'b0; size = 2'd2; sext = 1'b0; baddr = 32'h10; wdata = 32'h0;
    @(posedge clk); #1;
    push_req();
    size = 2'd0; sext = 1'b1; baddr = 32'h13;
    busy_window();
    @(posedge clk); #1;
    push_req();
    size = 2'd1; sext = 1'b0; baddr = 32'h12;
    busy_window();
    @(posedge clk); #1;
    push_req();
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic, mostly aligned.
    for (int t = 0; t < 300; t++) begin
      sz = 2'($urandom_range(0, 3));
      w  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) w[0] = 1'b0;
        if (sz == 2'd2) w[1:0] = 2'b00;
      end
      r = $urandom;
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), w, r, $urandom_range(0, 2));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle load/store initiator between the CPU datapath and the word-addressed data memory. It accepts one byte/halfword/word access request at a time. It converts the byte address into a word index plus byte enables, replicates store data onto the lanes the memory expects, and issues a single-cycle memory access. Load data is extracted, sign- or zero-extended and registered. Misaligned accesses and reserved sizes are flagged and never reach memory.

## Interface
Parameters:
- None; address and data widths are fixed at 32 bits.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  1  datapath access request; sampled only in IDLE
- we  in  1  1 = store, 0 = load; sampled with req
- size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- baddr  in  32  byte address
- wdata  in  32  store data, right-justified
- busy  out  1  high from the cycle after acceptance until back in IDLE
- done  out  1  one-cycle pulse: access completed
- err  out  1  one-cycle pulse: access rejected
- rdata  out  32  extended load result; holds until the next completed load
- DMWr  out  1  memory write enable
- addr  out  32  memory word index
- be  out  4  memory byte enables
- din  out  32  memory write data
- dout  in  32  memory read data; combinational from addr

## Operation
- FSM states: IDLE, ACCESS, DONE, ERR.
- IDLE with req=1, legal access:
  - register we, size, sext and baddr[1:0].
  - register addr = {2'b00, baddr[31:2]}.
  - register be and din.
  - go to ACCESS.
- IDLE with req=1, illegal access (size=11; halfword with baddr[0]=1; word with baddr[1:0]≠00): go to ERR. No memory outputs change.
- ACCESS, one cycle:
  - DMWr = we.
  - For a load, capture the extended value into rdata at the end of the cycle.
  - Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- ERR: err=1 for one cycle, then go to IDLE.
- Byte enables:
  - byte: 0001 / 0010 / 0100 / 1000 for baddr[1:0] = 0/1/2/3.
  - halfword: 0011 for baddr[1]=0, 1100 for baddr[1]=1.
  - word: 1111.
- Store data:
  - byte: din = {4{wdata[7:0]}}.
  - half: din = {2{wdata[15:0]}}.
  - word: din = wdata.
- Load extraction:
  - byte: lane dout[8*k+7:8*k] with k = baddr[1:0].
  - half: dout[31:16] if baddr[1]=1, else dout[15:0].
  - word: dout, with sext ignored.
  - Extension: sext=1 replicates the lane MSB into the upper bits; sext=0 fills them with zeros.
- Store completion leaves rdata unchanged.
- req outside IDLE is ignored and not queued.

## Timing
- Request accepted at edge N: ACCESS during cycle N+1 (DMWr high for exactly this cycle on stores). At edge N+2 the memory write commits and rdata is valid. done=1 during cycle N+2. IDLE again in cycle N+3, and a new req can be accepted at edge N+3.
- Error path: accepted at edge N, err=1 during cycle N+1, IDLE in cycle N+2.
- busy is high in ACCESS, DONE and ERR.
- DMWr is 0 in every state except ACCESS.
- be = 0000 outside ACCESS.
- addr and din hold their last values.
- Reset values: state IDLE; busy, done, err and DMWr = 0; addr, din and rdata = 0; be = 0000.
- Reset asserted mid-access forces DMWr=0 immediately (asynchronous), with no partial write. After reset deasserts, the aborted request produces neither done nor err.
- req held high continuously is accepted once every 3 cycles (legal) or every 2 cycles (illegal).

## Test plan
- Word store then load: store wdata=0xDEADBEEF to baddr=0x10. Required: addr=0x4, be=1111, din=0xDEADBEEF, DMWr high for one cycle. Then load word from 0x10: rdata=0xDEADBEEF, done pulses in cycle N+2.
- Byte lanes: with mem word 0x4 = 0x80FF7F01, load byte at baddr 0x10–0x13 with sext=1. Required rdata: 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80. With sext=0 the last two are 0x000000FF and 0x00000080.
- Half store/load:
  - store halfword 0x1234ABCD to baddr=0x12. Required: be=1100, din=0xABCDABCD, only the upper half of word 0x4 changes.
  - load halfword from 0x12, sext=1. Required: rdata=0xFFFFABCD.
- Misalignment: word access at baddr=0x11, half at 0x13, size=11. Each requires err pulse in cycle N+1, DMWr never high, memory unchanged, done never high.
- Reset mid-op: store accepted, rst asserted during ACCESS. Required: DMWr drops within the same cycle, target word unchanged, all outputs at reset values.
- Busy/back-to-back: req held high across three legal loads. Required: accepted at N, N+3, N+6; req during busy ignored; busy high in cycles N+1 to N+2.
